// File: rtl/qspi_flash_ctrl.sv
// Quad I/O Fast Read (0xEB) flash controller behind a req/gnt/rvalid memory port.
// Read-only: writes and addresses above 16 MiB answer at once with an error.
module qspi_flash_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    output logic        mem_gnt_o,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_rvalid_o,
    output logic        mem_err_o,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  qspi_io_i,
    output logic [3:0]  qspi_io_o,
    output logic [3:0]  qspi_io_t,
    output logic        qspi_ck_o,
    output logic        qspi_cs_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_RESP
    } state_t;

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
    localparam logic [7:0] CMD_QREAD  = 8'hEB;

    state_t      r_state;
    logic [3:0]  r_div;
    logic [3:0]  r_cnt;
    logic        r_ck;
    logic        r_cs;
    logic [3:0]  r_io_o;
    logic [3:0]  r_io_t;
    logic [31:0] r_sh;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_gnt;
    logic        w_bad_req;
    logic [31:0] w_sh1;
    logic [31:0] w_sh4;
    logic        w_unused;

    assign w_gnt     = mem_req_i & (r_state == S_IDLE) & rst;
    assign w_bad_req = mem_we_i | (mem_addr_i[31:24] != 8'h00);
    assign w_sh1     = {r_sh[30:0], 1'b0};
    assign w_sh4     = {r_sh[27:0], 4'h0};
    assign w_unused  = ^{mem_be_i, mem_wdata_i, mem_addr_i[1:0]};

    // r_sh carries {cmd, addr} outbound; its top bit(s) are what the pins show.
    // During DATA it collects nibbles in flash order, byte-swapped at the end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_div    <= 4'd0;
            r_cnt    <= 4'd0;
            r_ck     <= 1'b0;
            r_cs     <= 1'b1;
            r_io_o   <= 4'h0;
            r_io_t   <= 4'hF;
            r_sh     <= 32'h0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_div <= 4'd0;
                        r_cnt <= 4'd0;
                        r_ck  <= 1'b0;
                        if (w_bad_req) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                        end else begin
                            r_state <= S_CMD;
                            r_cs    <= 1'b0;
                            r_sh    <= {CMD_QREAD, mem_addr_i[23:2], 2'b00};
                            r_io_o  <= {3'b110, CMD_QREAD[7]};
                            r_io_t  <= 4'b0010;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 4'd1;
                    end else begin
                        r_div <= 4'd0;
                        r_ck  <= ~r_ck;
                        if (!r_ck) begin
                            if (r_state == S_DATA)
                                r_sh <= {r_sh[27:0], qspi_io_i};
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            case (r_state)
                                S_CMD: begin
                                    r_sh <= w_sh1;
                                    if (r_cnt == 4'd7) begin
                                        r_state <= S_ADDR;
                                        r_cnt   <= 4'd0;
                                        r_io_o  <= w_sh1[31:28];
                                        r_io_t  <= 4'b0000;
                                    end else begin
                                        r_io_o <= {3'b110, w_sh1[31]};
                                    end
                                end
                                S_ADDR: begin
                                    r_sh <= w_sh4;
                                    if (r_cnt == 4'd5) begin
                                        r_state <= S_MODE;
                                        r_cnt   <= 4'd0;
                                        r_io_o  <= 4'h0;
                                    end else begin
                                        r_io_o <= w_sh4[31:28];
                                    end
                                end
                                S_MODE: begin
                                    if (r_cnt == 4'd1) begin
                                        r_state <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                                        r_cnt   <= 4'd0;
                                        r_io_o  <= 4'h0;
                                        r_io_t  <= 4'hF;
                                    end
                                end
                                S_DUMMY: begin
                                    if (r_cnt == DUMMY_LAST) begin
                                        r_state <= S_DATA;
                                        r_cnt   <= 4'd0;
                                    end
                                end
                                S_DATA: begin
                                    if (r_cnt == 4'd7) begin
                                        r_state  <= S_RESP;
                                        r_cnt    <= 4'd0;
                                        r_cs     <= 1'b1;
                                        r_rvalid <= 1'b1;
                                        r_rdata  <= {r_sh[7:0], r_sh[15:8],
                                                     r_sh[23:16], r_sh[31:24]};
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign mem_gnt_o    = w_gnt;
    assign mem_rvalid_o = r_rvalid;
    assign mem_err_o    = r_err;
    assign mem_rdata_o  = r_rdata;
    assign qspi_io_o    = r_io_o;
    assign qspi_io_t    = r_io_t;
    assign qspi_ck_o    = r_ck;
    assign qspi_cs_o    = r_cs;

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Directed bench for qspi_flash_ctrl: default instance with a flash stub,
// plus a CLK_DIV=1 / DUMMY_CYCLES=0 instance fed a constant nibble.
module tb_qspi_flash_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a, req_b, we;
    logic [31:0] addr;

    logic        gnt_a, rvalid_a, err_a, ck_a, cs_a;
    logic [31:0] rdata_a;
    logic [3:0]  io_i_a, io_o_a, io_t_a;

    logic        gnt_b, rvalid_b, err_b, ck_b, cs_b;
    logic [31:0] rdata_b;
    logic [3:0]  io_i_b, io_o_b, io_t_b;

    qspi_flash_ctrl #(.CLK_DIV(2), .DUMMY_CYCLES(6)) u_a (
        .clk(clk), .rst(rst),
        .mem_req_i(req_a), .mem_gnt_o(gnt_a),
        .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(4'hF), .mem_wdata_i(32'h0),
        .mem_rvalid_o(rvalid_a), .mem_err_o(err_a), .mem_rdata_o(rdata_a),
        .qspi_io_i(io_i_a), .qspi_io_o(io_o_a), .qspi_io_t(io_t_a),
        .qspi_ck_o(ck_a), .qspi_cs_o(cs_a)
    );

    qspi_flash_ctrl #(.CLK_DIV(1), .DUMMY_CYCLES(0)) u_b (
        .clk(clk), .rst(rst),
        .mem_req_i(req_b), .mem_gnt_o(gnt_b),
        .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(4'hF), .mem_wdata_i(32'h0),
        .mem_rvalid_o(rvalid_b), .mem_err_o(err_b), .mem_rdata_o(rdata_b),
        .qspi_io_i(io_i_b), .qspi_io_o(io_o_b), .qspi_io_t(io_t_b),
        .qspi_ck_o(ck_b), .qspi_cs_o(cs_b)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cs"}, 32'(cs_a), 32'd1);
        chk({tag, "_ck"}, 32'(ck_a), 32'd0);
        chk({tag, "_iot"}, 32'(io_t_a), 32'hF);
        chk({tag, "_ioo"}, 32'(io_o_a), 32'h0);
        chk({tag, "_gnt"}, 32'(gnt_a), 32'd0);
        chk({tag, "_rv"}, 32'(rvalid_a), 32'd0);
        chk({tag, "_err"}, 32'(err_a), 32'd0);
        chk({tag, "_rdata"}, rdata_a, 32'h0);
    endtask

    // Flash stub: decodes cmd/addr/mode on SCK rise, drives data on SCK fall.
    logic [7:0]  fmem [0:511];
    int          sck_r;
    int          t_bad;
    int          stub_k;
    logic [7:0]  stub_b;
    logic [7:0]  cap_cmd;
    logic [23:0] cap_addr;
    logic [7:0]  cap_mode;

    always @(negedge cs_a) begin
        sck_r    = 0;
        t_bad    = 0;
        cap_cmd  = 8'h0;
        cap_addr = 24'h0;
        cap_mode = 8'h0;
    end

    always @(posedge ck_a) begin
        if (!cs_a) begin
            if (sck_r < 8) begin
                cap_cmd = {cap_cmd[6:0], io_o_a[0]};
                if (io_t_a !== 4'b0010 || io_o_a[3:2] !== 2'b11) t_bad++;
            end else if (sck_r < 14) begin
                cap_addr = {cap_addr[19:0], io_o_a};
                if (io_t_a !== 4'b0000) t_bad++;
            end else if (sck_r < 16) begin
                cap_mode = {cap_mode[3:0], io_o_a};
                if (io_t_a !== 4'b0000) t_bad++;
            end else if (io_t_a !== 4'hF) begin
                t_bad++;
            end
            sck_r++;
        end
    end

    always @(negedge ck_a) begin
        if (!cs_a && sck_r >= 22 && sck_r < 30) begin
            stub_k = sck_r - 22;
            stub_b = fmem[(int'(cap_addr) + stub_k / 2) % 512];
            io_i_a = (stub_k % 2 == 0) ? stub_b[7:4] : stub_b[3:0];
        end
    end

    int cs_low_n = 0;
    int ck_edge_n = 0;
    int rv_n = 0;
    always @(posedge clk) begin
        if (!cs_a) cs_low_n++;
        if (rvalid_a) rv_n++;
    end
    always @(posedge ck_a) ck_edge_n++;

    int n;
    int gb;
    int rv0;
    int tog_bad;

    initial begin
        rst    = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        we     = 1'b0;
        addr   = 32'h0;
        io_i_a = 4'h0;
        io_i_b = 4'hA;
        for (int i = 0; i < 512; i++) fmem[i] = 8'h00;
        fmem[9'h104] = 8'h11;
        fmem[9'h105] = 8'h22;
        fmem[9'h106] = 8'h33;
        fmem[9'h107] = 8'h44;
        fmem[9'h1F0] = 8'hDE;
        fmem[9'h1F1] = 8'hAD;
        fmem[9'h1F2] = 8'hBE;
        fmem[9'h1F3] = 8'hEF;

        repeat (3) @(posedge clk);
        #1 chk_rst("por");
        @(negedge clk) rst = 1'b1;

        // reset pulse while idle
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk_rst("idle");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // single read at defaults
        @(posedge clk);
        @(negedge clk);
        addr  = 32'h0000_0106;
        req_a = 1'b1;
        #1 chk("rd_gnt0", 32'(gnt_a), 32'd1);
        @(posedge clk);
        #1 req_a = 1'b0;
        n = 1;
        chk("rd_cs1", 32'(cs_a), 32'd0);
        while (!rvalid_a && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("rd_lat", n, 32'd121);
        chk("rd_data", rdata_a, 32'h4433_2211);
        chk("rd_err", 32'(err_a), 32'd0);
        chk("rd_cmd", 32'(cap_cmd), 32'hEB);
        chk("rd_addr", 32'(cap_addr), 32'h00_0104);
        chk("rd_mode", 32'(cap_mode), 32'h00);
        chk("rd_iot", t_bad, 32'd0);
        @(posedge clk);
        #1 chk("rd_rv_pulse", 32'(rvalid_a), 32'd0);

        // write request
        @(posedge clk);
        @(negedge clk);
        cs_low_n  = 0;
        ck_edge_n = 0;
        addr  = 32'h0000_0010;
        we    = 1'b1;
        req_a = 1'b1;
        @(posedge clk);
        #1 req_a = 1'b0;
        we = 1'b0;
        chk("wr_rv", 32'(rvalid_a), 32'd1);
        chk("wr_err", 32'(err_a), 32'd1);
        chk("wr_rdata", rdata_a, 32'h0);

        // out of range
        @(posedge clk);
        @(negedge clk);
        addr  = 32'h0100_0000;
        req_a = 1'b1;
        @(posedge clk);
        #1 req_a = 1'b0;
        chk("oor_rv", 32'(rvalid_a), 32'd1);
        chk("oor_err", 32'(err_a), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("err_cs_low", cs_low_n, 32'd0);
        chk("err_sck", ck_edge_n, 32'd0);

        // back-to-back with req held
        @(negedge clk);
        addr  = 32'h0000_0104;
        req_a = 1'b1;
        #1 chk("bb_gnt0", 32'(gnt_a), 32'd1);
        @(posedge clk);
        #1 n = 1;
        gb = 0;
        while (!rvalid_a && n < 200) begin
            if (gnt_a) gb++;
            @(posedge clk);
            #1 n++;
        end
        chk("bb1_lat", n, 32'd121);
        chk("bb1_data", rdata_a, 32'h4433_2211);
        chk("bb_gnt_resp", 32'(gnt_a), 32'd0);
        chk("bb_cs_resp", 32'(cs_a), 32'd1);
        addr = 32'h0000_01F0;
        @(posedge clk);
        #1 chk("bb_gnt2", 32'(gnt_a), 32'd1);
        chk("bb_cs_gap", 32'(cs_a), 32'd1);
        @(posedge clk);
        #1 req_a = 1'b0;
        n = 1;
        chk("bb2_cs1", 32'(cs_a), 32'd0);
        while (!rvalid_a && n < 200) begin
            if (gnt_a) gb++;
            @(posedge clk);
            #1 n++;
        end
        chk("bb2_lat", n, 32'd121);
        chk("bb2_data", rdata_a, 32'hEFBE_ADDE);
        chk("bb2_addr", 32'(cap_addr), 32'h00_01F0);
        chk("bb_busy_gnt", gb, 32'd0);

        // reset in the middle of DATA
        @(posedge clk);
        @(negedge clk);
        addr  = 32'h0000_0104;
        req_a = 1'b1;
        @(posedge clk);
        #1 req_a = 1'b0;
        rv0 = rv_n;
        repeat (99) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk_rst("data");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (150) @(posedge clk);
        #1 chk("abort_no_rv", rv_n, rv0);

        // CLK_DIV=1, DUMMY_CYCLES=0
        @(negedge clk);
        addr  = 32'h0000_0200;
        req_b = 1'b1;
        #1 chk("p_gnt0", 32'(gnt_b), 32'd1);
        @(posedge clk);
        #1 req_b = 1'b0;
        n = 1;
        tog_bad = 0;
        while (!rvalid_b && n < 200) begin
            if (ck_b !== ((n % 2) == 0)) tog_bad++;
            @(posedge clk);
            #1 n++;
        end
        chk("p_lat", n, 32'd49);
        chk("p_data", rdata_b, 32'hAAAA_AAAA);
        chk("p_err", 32'(err_b), 32'd0);
        chk("p_sck", tog_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qspi_flash_ctrl.md
# qspi_flash_ctrl

Single-master quad-SPI flash read controller. It turns word requests on the Vicuna/Ibex-style memory port into Quad I/O Fast Read (0xEB) transactions on the external storage QSPI pins (`external_qspi_*` in `toplevel_498`). It owns the bus sequencing: chip select, SCK generation, per-phase pin direction, nibble serialisation and capture. Writes and out-of-range addresses complete immediately with an error; the flash is read-only from the core side.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range 1..15.
- `DUMMY_CYCLES`, default 6: SCK cycles of dummy phase after the mode byte; legal range 0..15.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-low reset.
- `mem_req_i`, in, 1: request valid.
- `mem_gnt_o`, out, 1: request accepted. Combinational: `mem_req_i & (state==IDLE)`.
- `mem_addr_i`, in, 32: byte address.
- `mem_we_i`, in, 1: write request.
- `mem_be_i`, in, 4: byte enables. Ignored.
- `mem_wdata_i`, in, 32: write data. Ignored.
- `mem_rvalid_o`, out, 1: one-cycle response pulse.
- `mem_err_o`, out, 1: error; valid only with `mem_rvalid_o`.
- `mem_rdata_o`, out, 32: read data; valid only with `mem_rvalid_o`.
- `qspi_io_i`, in, 4: pin inputs.
- `qspi_io_o`, out, 4: pin outputs.
- `qspi_io_t`, out, 4: per-pin tristate; 1 = released/input.
- `qspi_ck_o`, out, 1: SCK, mode 0 (idle low).
- `qspi_cs_o`, out, 1: chip select, active low.

## Operation
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, RESP.
- Accept occurs when `mem_gnt_o` is high at a rising `clk` edge. On accept, latch the address and classify the request.
  - Error request: `mem_we_i`=1, or `mem_addr_i[31:24]`≠0. Go directly to RESP with the error flag set. No pin activity.
  - Read request: flash address = `{mem_addr_i[23:2],2'b00}`. Go to CMD and assert `qspi_cs_o`=0.
- Each SCK cycle is CLK_DIV `clk` cycles low followed by CLK_DIV cycles high.
  - Outputs change only at the start of a low phase.
  - `qspi_io_i` is registered on the `clk` edge where `qspi_ck_o` rises.
- CMD, 8 SCK cycles: 0xEB, MSB first, on IO0. `io_t`=4'b0010; `io_o[3:2]`=2'b11 (WP#/HOLD# high).
- ADDR, 6 SCK cycles: 24-bit address, nibble MSB first, `io_t`=4'b0000.
- MODE, 2 SCK cycles: 0x00 (no continuous-read), `io_t`=4'b0000.
- DUMMY: DUMMY_CYCLES SCK cycles, `io_t`=4'b1111. Skipped when DUMMY_CYCLES=0.
- DATA, 8 SCK cycles, `io_t`=4'b1111.
  - Nibble k (k=0..7) is captured; byte b=k/2.
  - Even k fills `rdata[8b+7:8b+4]`; odd k fills `rdata[8b+3:8b]`. Result is little-endian: the byte at the flash address lands in `[7:0]`.
- RESP, 1 cycle: `qspi_cs_o`=1, `qspi_ck_o`=0, `io_t`=4'b1111. `mem_rvalid_o`=1, `mem_err_o`=error flag, `mem_rdata_o`=assembled word (0 on error). Then IDLE.
- Phase counters: SCK-cycle counter 4 bits, divider counter 4 bits. Each counter resets on every phase change.
- IDLE: `cs`=1, `ck`=0, `io_t`=4'b1111, `io_o`=0.

## Timing
- Reset (`rst`=0 at a rising edge) forces these values on the next cycle, from any state:
  - `qspi_cs_o`=1, `qspi_ck_o`=0, `qspi_io_t`=4'hF, `qspi_io_o`=0.
  - `mem_gnt_o`=0, `mem_rvalid_o`=0, `mem_err_o`=0, `mem_rdata_o`=0.
  - State returns to IDLE. An in-flight transaction is dropped and never gets `rvalid`.
- Accept at cycle 0.
  - Error path: `rvalid`+`err` at cycle 1.
  - Read path: `cs` low from cycle 1. N = 24+DUMMY_CYCLES SCK cycles. RESP at cycle 1+2·CLK_DIV·N.
  - Defaults (CLK_DIV=2, DUMMY_CYCLES=6): N=30, `rvalid` at cycle 121.
- Gnt is asserted no earlier than the cycle after RESP, so `cs` stays high for at least 2 `clk` cycles between transactions.
- One outstanding request at a time. `mem_req_i` held during a busy state sees `gnt`=0 and is not lost.

## Test plan
- Reset: hold `rst`=0 for 3 cycles mid-idle and mid-DATA → all outputs at reset values the cycle after; no `rvalid` ever appears for the aborted read.
- Single read, defaults: stub flash bytes 0x104..0x107 = 11,22,33,44; `req` addr 0x00000106.
  - `gnt` at cycle 0.
  - Pins carry 0xEB on IO0, then address nibbles 0,0,0,1,0,4, then mode 0,0.
  - `rvalid` at cycle 121 with `rdata`=0x44332211, `err`=0.
- Write: `req` `we`=1 addr 0x10 → `rvalid`=1, `err`=1, `rdata`=0 at cycle 1; `cs` never low.
- Out of range: addr 0x01000000 → `err` at cycle 1; no SCK edges.
- Back-to-back: `req` held high for two reads → second `gnt` one cycle after the first `rvalid`; `cs` high ≥2 cycles between them; both data words correct.
- Parameters: CLK_DIV=1, DUMMY_CYCLES=0 → `rvalid` at cycle 49; SCK toggles every `clk`.
